// File: rtl/tag_free_allocator.sv
// -----------------------------------------------------------------------------
// tag_free_allocator
//
// Hands out free physical register tags to the rename stage and takes them back
// at commit. Two occupancy bitmaps are kept:
//   spec_used - tags allocated speculatively or currently parked in staging
//   comm_used - tags held by the committed architectural state
// A small registered staging buffer holds pre-picked free tags. The priority
// encode that finds free tags therefore runs one cycle ahead and stays off the
// rename critical path. A mispredict restores spec_used from comm_used.
//
// Ports
//   clk                 clock, all state updates on the rising edge
//   rst                 asynchronous active-high reset
//   IN_mispred          restore speculative state from committed state
//   IN_issueValid       per rename slot: consume the staged tag this cycle
//   OUT_issueTags       per rename slot: staged tag (registered, slot 0 in LSBs)
//   OUT_issueTagsValid  per rename slot: staged tag is usable (registered)
//   IN_commitValid      per commit slot: commit active
//   IN_commitTags       per commit slot: newly committed tag
//   IN_commitPrevTags   per commit slot: tag displaced by the commit, freed here
//   OUT_freeCount       free tags not held in staging (registered)
//
// A tag with its MSB set means "no physical tag" and is ignored wherever it
// appears on the commit inputs.
// -----------------------------------------------------------------------------
module tag_free_allocator #(
    parameter int NUM_ISSUE  = 4,
    parameter int NUM_COMMIT = 4,
    parameter int TAG_SIZE   = 7,
    parameter int NUM_TAGS   = 2 ** (TAG_SIZE - 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           IN_mispred,
    input  logic [NUM_ISSUE-1:0]           IN_issueValid,
    output logic [NUM_ISSUE*TAG_SIZE-1:0]  OUT_issueTags,
    output logic [NUM_ISSUE-1:0]           OUT_issueTagsValid,
    input  logic [NUM_COMMIT-1:0]          IN_commitValid,
    input  logic [NUM_COMMIT*TAG_SIZE-1:0] IN_commitTags,
    input  logic [NUM_COMMIT*TAG_SIZE-1:0] IN_commitPrevTags,
    output logic [TAG_SIZE-1:0]            OUT_freeCount
);

    localparam int                  IDX_W  = TAG_SIZE - 1;
    localparam logic [TAG_SIZE-1:0] NO_TAG = {1'b1, {IDX_W{1'b0}}};

    logic [NUM_TAGS-1:0]  spec_used;
    logic [NUM_TAGS-1:0]  spec_next;
    logic [NUM_TAGS-1:0]  comm_used;
    logic [NUM_TAGS-1:0]  comm_next;
    logic [TAG_SIZE-1:0]  stg_tag      [NUM_ISSUE];
    logic [TAG_SIZE-1:0]  stg_tag_next [NUM_ISSUE];
    logic [NUM_ISSUE-1:0] stg_valid;
    logic [NUM_ISSUE-1:0] stg_valid_next;
    logic [TAG_SIZE-1:0]  free_count;
    logic [TAG_SIZE-1:0]  free_count_next;

    // Up to NUM_ISSUE lowest-index free tags, taken from the registered
    // spec_used so this cycle's commit frees never feed the encoder directly.
    logic [IDX_W-1:0]     pick_idx [NUM_ISSUE];
    logic [NUM_ISSUE-1:0] pick_ok;

    // -------------------------------------------------------------------------
    // Free-tag picker: k-th pick is the k-th lowest clear bit of spec_used.
    // Picks are contiguous: once one fails, all later ones fail too.
    // -------------------------------------------------------------------------
    always_comb begin : pick_free
        logic [NUM_TAGS-1:0] avail;
        // NOTE: every variable written here gets a default before any branch,
        // so no path can leave one unassigned and infer a latch.
        avail    = ~spec_used;
        pick_ok  = '0;
        pick_idx = '{default: '0};
        for (int k = 0; k < NUM_ISSUE; k++) begin
            for (int t = 0; t < NUM_TAGS; t++) begin
                if (!pick_ok[k] && avail[t]) begin
                    pick_ok[k]  = 1'b1;
                    pick_idx[k] = IDX_W'(t);
                end
            end
            if (pick_ok[k]) begin
                avail[pick_idx[k]] = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state: commits, then either mispredict restore or staging refill.
    // -------------------------------------------------------------------------
    always_comb begin : next_state
        logic [TAG_SIZE-1:0] new_tag;
        logic [TAG_SIZE-1:0] prev_tag;
        int                  n;

        comm_next       = comm_used;
        spec_next       = spec_used;
        stg_tag_next    = stg_tag;
        stg_valid_next  = stg_valid & ~IN_issueValid;
        free_count_next = '0;
        new_tag         = '0;
        prev_tag        = '0;
        n               = 0;

        // Slot order matters: a later slot wins on a shared tag.
        for (int c = 0; c < NUM_COMMIT; c++) begin
            if (IN_commitValid[c]) begin
                new_tag  = IN_commitTags[c*TAG_SIZE +: TAG_SIZE];
                prev_tag = IN_commitPrevTags[c*TAG_SIZE +: TAG_SIZE];
                if (!new_tag[TAG_SIZE-1]) begin
                    comm_next[new_tag[IDX_W-1:0]] = 1'b1;
                end
                if (!prev_tag[TAG_SIZE-1]) begin
                    comm_next[prev_tag[IDX_W-1:0]] = 1'b0;
                    spec_next[prev_tag[IDX_W-1:0]] = 1'b0;
                end
            end
        end

        if (IN_mispred) begin
            // Staged tags are not in comm_used, so the restore frees them.
            spec_next      = comm_next;
            stg_valid_next = '0;
            stg_tag_next   = '{default: NO_TAG};
        end else begin
            // Empty slots (invalid or consumed) take picks in ascending order.
            for (int i = 0; i < NUM_ISSUE; i++) begin
                if (!stg_valid[i] || IN_issueValid[i]) begin
                    if (pick_ok[n]) begin
                        stg_valid_next[i]      = 1'b1;
                        stg_tag_next[i]        = {1'b0, pick_idx[n]};
                        spec_next[pick_idx[n]] = 1'b1;
                    end else begin
                        stg_valid_next[i] = 1'b0;
                        stg_tag_next[i]   = NO_TAG;
                    end
                    n++;
                end
            end
        end

        for (int t = 0; t < NUM_TAGS; t++) begin
            free_count_next = free_count_next + TAG_SIZE'(!spec_next[t]);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_used  <= '0;
            comm_used  <= '0;
            stg_valid  <= '0;
            // NOTE: the staging array is a handful of flops, not a RAM, so it is
            // reset with everything else; its tags must read "no tag" at reset.
            stg_tag    <= '{default: NO_TAG};
            free_count <= TAG_SIZE'(NUM_TAGS);
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values computed above, independent of statement order.
            spec_used  <= spec_next;
            comm_used  <= comm_next;
            stg_valid  <= stg_valid_next;
            stg_tag    <= stg_tag_next;
            free_count <= free_count_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs come straight from registers.
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_ISSUE; i++) begin : g_out
        assign OUT_issueTags[i*TAG_SIZE +: TAG_SIZE] = stg_tag[i];
    end

    assign OUT_issueTagsValid = stg_valid;
    assign OUT_freeCount      = free_count;

endmodule

// File: tb/tb_tag_free_allocator.sv
// -----------------------------------------------------------------------------
// tb_tag_free_allocator
//
// Directed scenarios followed by a randomized stream, all checked against a
// free-list reference model that works from the allocation rules: a sorted
// queue of free tags is drained into empty staging slots each cycle.
// -----------------------------------------------------------------------------
module tb_tag_free_allocator;

    localparam int NI = 4;
    localparam int NC = 4;
    localparam int TS = 7;
    localparam int NT = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             mispred;
    logic [NI-1:0]    issue_v;
    logic [NI*TS-1:0] out_tags;
    logic [NI-1:0]    out_valid;
    logic [NC-1:0]    cv;
    logic [NC*TS-1:0] ct;
    logic [NC*TS-1:0] cp;
    logic [TS-1:0]    free_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_spec [NT];
    bit m_comm [NT];
    bit m_v    [NI];
    int m_tag  [NI];
    int m_free;
    int inflight[$];   // consumed, not yet committed, oldest first
    int arch_q[$];     // committed tags that a later commit may displace

    always #5 clk = ~clk;

    tag_free_allocator dut (
        .clk                (clk),
        .rst                (rst),
        .IN_mispred         (mispred),
        .IN_issueValid      (issue_v),
        .OUT_issueTags      (out_tags),
        .OUT_issueTagsValid (out_valid),
        .IN_commitValid     (cv),
        .IN_commitTags      (ct),
        .IN_commitPrevTags  (cp),
        .OUT_freeCount      (free_cnt)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin
            m_spec[t] = 1'b0;
            m_comm[t] = 1'b0;
        end
        for (int i = 0; i < NI; i++) begin
            m_v[i]   = 1'b0;
            m_tag[i] = 'h40;
        end
        m_free = NT;
        inflight.delete();
        arch_q.delete();
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        int free_q[$];
        bit nspec [NT];
        logic [TS-1:0] nt;
        logic [TS-1:0] pt;
        for (int t = 0; t < NT; t++) begin
            if (!m_spec[t]) free_q.push_back(t);
        end
        for (int i = 0; i < NI; i++) begin
            if (!mispred && m_v[i] && issue_v[i]) inflight.push_back(m_tag[i]);
        end
        nspec = m_spec;
        for (int c = 0; c < NC; c++) begin
            if (cv[c]) begin
                nt = ct[c*TS +: TS];
                pt = cp[c*TS +: TS];
                if (!nt[6]) m_comm[nt[5:0]] = 1'b1;
                if (!pt[6]) begin
                    m_comm[pt[5:0]] = 1'b0;
                    nspec[pt[5:0]]  = 1'b0;
                end
            end
        end
        if (mispred) begin
            nspec = m_comm;
            for (int i = 0; i < NI; i++) m_v[i] = 1'b0;
            inflight.delete();
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (!m_v[i] || issue_v[i]) begin
                    if (free_q.size() > 0) begin
                        m_tag[i]        = free_q.pop_front();
                        m_v[i]          = 1'b1;
                        nspec[m_tag[i]] = 1'b1;
                    end else begin
                        m_v[i] = 1'b0;
                    end
                end
            end
        end
        m_spec = nspec;
        m_free = 0;
        for (int t = 0; t < NT; t++) begin
            if (!m_spec[t]) m_free++;
        end
    endtask

    task automatic compare_model();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("slot%0d_valid", i), 32'(out_valid[i]), 32'(m_v[i]));
            if (m_v[i]) check($sformatf("slot%0d_tag", i), 32'(out_tags[i*TS +: TS]), m_tag[i]);
        end
        check("free_count", 32'(free_cnt), m_free);
    endtask

    task automatic set_commit(input int s, input logic [TS-1:0] n, input logic [TS-1:0] p);
        cv[s]          = 1'b1;
        ct[s*TS +: TS] = n;
        cp[s*TS +: TS] = p;
    endtask

    // One clock: model, edge, sample 1 time unit later, then idle the inputs.
    task automatic step(input logic [NI-1:0] iv, input logic mp);
        issue_v = iv;
        mispred = mp;
        model_step();
        @(posedge clk);
        #1;
        compare_model();
        issue_v = '0;
        mispred = 1'b0;
        cv      = '0;
        ct      = {NC{7'h40}};
        cp      = {NC{7'h40}};
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic async_reset();
        #3;
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_tags", 32'(out_tags), 32'(exp_reset_tags()));
        check("rst_free", 32'(free_cnt), 32'd64);
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [NI*TS-1:0] exp_reset_tags();
        return {NI{7'h40}};
    endfunction

    initial begin : main
        logic [NI*TS-1:0] exp_tags;
        logic [TS-1:0]    nt;
        logic [TS-1:0]    pt;

        rst     = 1'b1;
        mispred = 1'b0;
        issue_v = '0;
        cv      = '0;
        ct      = {NC{7'h40}};
        cp      = {NC{7'h40}};
        model_reset();

        // Reset state, then first fill.
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(out_valid), 32'h0);
        check("reset_tags", 32'(out_tags), 32'(exp_reset_tags()));
        check("reset_free", 32'(free_cnt), 32'd64);
        rst = 1'b0;
        step('0, 1'b0);
        exp_tags = {7'd3, 7'd2, 7'd1, 7'd0};
        check("first_fill_tags", 32'(out_tags), 32'(exp_tags));
        check("first_fill_valid", 32'(out_valid), 32'hF);
        check("first_fill_free", 32'(free_cnt), 32'd60);

        // Drain every tag four per cycle.
        for (int k = 0; k < 16; k++) begin
            step(4'hF, 1'b0);
            if (k < 15) check("drain_slot0_tag", 32'(out_tags[TS-1:0]), 32'(4 * k + 4));
        end
        check("exhausted_valid", 32'(out_valid), 32'h0);
        check("exhausted_free", 32'(free_cnt), 32'd0);

        // Free tag 5 at commit while exhausted: visible two cycles later.
        set_commit(0, 7'd60, 7'd5);
        step('0, 1'b0);
        check("free5_not_yet", 32'(out_valid[0]), 32'h0);
        step('0, 1'b0);
        check("free5_slot0_valid", 32'(out_valid[0]), 32'h1);
        check("free5_slot0_tag", 32'(out_tags[TS-1:0]), 32'd5);
        check("free5_free", 32'(free_cnt), 32'd0);

        // Mispredict restore.
        async_reset();
        step('0, 1'b0);
        step(4'hF, 1'b0);
        step(4'hF, 1'b0);
        set_commit(0, 7'd0, 7'h40);
        set_commit(1, 7'd1, 7'h40);
        step('0, 1'b0);
        step('0, 1'b1);
        check("mispred_valid", 32'(out_valid), 32'h0);
        check("mispred_free", 32'(free_cnt), 32'd62);
        step('0, 1'b0);
        exp_tags = {7'd5, 7'd4, 7'd3, 7'd2};
        check("restore_tags", 32'(out_tags), 32'(exp_tags));
        check("restore_valid", 32'(out_valid), 32'hF);
        check("restore_free", 32'(free_cnt), 32'd58);

        // Slot 1 freeing tag 9 overrides slot 0 committing it.
        step(4'hF, 1'b0);
        step(4'hF, 1'b0);
        check("pre_override_free", 32'(free_cnt), 32'd50);
        set_commit(0, 7'd9, 7'h40);
        set_commit(1, 7'h40, 7'd9);
        step('0, 1'b0);
        check("override_spec_free", 32'(free_cnt), 32'd51);
        step(4'b0001, 1'b0);
        check("override_refill_tag", 32'(out_tags[TS-1:0]), 32'd9);
        step('0, 1'b1);
        check("override_comm_free", 32'(free_cnt), 32'd62);
        step('0, 1'b0);

        // Asynchronous reset mid-stream; refill restarts at tag 0.
        step(4'b0101, 1'b0);
        async_reset();
        step('0, 1'b0);
        exp_tags = {7'd3, 7'd2, 7'd1, 7'd0};
        check("post_rst_tags", 32'(out_tags), 32'(exp_tags));

        // Randomized rename/commit/mispredict traffic.
        for (int r = 0; r < 400; r++) begin
            for (int c = 0; c < NC; c++) begin
                if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
                    nt = TS'(inflight.pop_front());
                    pt = (arch_q.size() > 6) ? TS'(arch_q.pop_front()) : 7'h40;
                    arch_q.push_back(int'(nt));
                    set_commit(c, nt, pt);
                end
            end
            step(NI'($urandom), ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
